// File: rtl/toy_bus_pkg.sv
// Shared ToyBus ACK types and the route-map lookup used by the decode nodes.
package toy_bus_pkg;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_ID_W    = 4;
    localparam int MAX_OUT_NUM = 8;
    localparam int MAX_ID_W    = 8;
    localparam int MAP_MAX_W   = (2 ** MAX_ID_W) * MAX_OUT_NUM;

    typedef struct packed {
        logic                  opcode;
        logic [DEF_DATA_W-1:0] data;
        logic [DEF_ID_W-1:0]   src_id;
        logic [DEF_ID_W-1:0]   tgt_id;
    } toy_bus_ack_t;

    // Channel mask for one target; bits at or above n are forced to zero.
    function automatic logic [MAX_OUT_NUM-1:0] get_route_mask(
        input logic [MAP_MAX_W-1:0] map,
        input int unsigned          tgt,
        input int unsigned          n
    );
        logic [MAX_OUT_NUM-1:0] mask;
        logic [MAX_OUT_NUM-1:0] keep;
        mask = map[tgt*n +: MAX_OUT_NUM];
        keep = MAX_OUT_NUM'((32'd1 << n) - 32'd1);
        return mask & keep;
    endfunction

    function automatic int unsigned count_ones(input logic [MAX_OUT_NUM-1:0] v);
        int unsigned c;
        c = 0;
        for (int i = 0; i < MAX_OUT_NUM; i++) begin
            c = c + int'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/toy_bus_skid_buf.sv
// Two-entry valid/ready buffer. Output fields come straight from the head register,
// and in_rdy depends only on the fill level, never on out_rdy.
module toy_bus_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic [W-1:0] in_data,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [W-1:0] out_data
);

    logic [1:0]   count;
    logic [W-1:0] head;
    logic [W-1:0] tail;
    logic         push;
    logic         pop;

    assign in_rdy   = (count != 2'd2);
    assign out_vld  = (count != 2'd0);
    assign out_data = head;
    assign push     = in_vld & in_rdy;
    assign pop      = out_vld & out_rdy;

    // A simultaneous push and pop can only happen with one entry held, so the new beat becomes head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 2'd0;
            head  <= '0;
            tail  <= '0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) head <= in_data;
                    else               tail <= in_data;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head  <= tail;
                    count <= count - 2'd1;
                end
                2'b11: head <= in_data;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/toy_bus_ddec_node_reg.sv
// Registered ACK decode node: steers each ToyBusAck beat to one output channel by tgt_id,
// buffering every channel in its own skid buffer and dropping beats for unmapped targets.
module toy_bus_ddec_node_reg
    import toy_bus_pkg::*;
#(
    parameter int                               OUT_NUM   = 2,
    parameter int                               DATA_W    = DEF_DATA_W,
    parameter int                               ID_W      = DEF_ID_W,
    parameter logic [(2**ID_W)*OUT_NUM-1:0]     ROUTE_MAP = 32'h0000_2009,
    parameter int                               ERR_CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in0_vld,
    output logic                       in0_rdy,
    input  logic                       in0_opcode,
    input  logic [DATA_W-1:0]          in0_data,
    input  logic [ID_W-1:0]            in0_src_id,
    input  logic [ID_W-1:0]            in0_tgt_id,
    output logic [OUT_NUM-1:0]         out_vld,
    input  logic [OUT_NUM-1:0]         out_rdy,
    output logic [OUT_NUM-1:0]         out_opcode,
    output logic [OUT_NUM*DATA_W-1:0]  out_data,
    output logic [OUT_NUM*ID_W-1:0]    out_src_id,
    output logic [OUT_NUM*ID_W-1:0]    out_tgt_id,
    output logic                       err_vld,
    output logic [ID_W-1:0]            err_tgt_id,
    output logic [ERR_CNT_W-1:0]       err_cnt
);

    localparam int                   PAY_W   = 1 + DATA_W + 2 * ID_W;
    localparam logic [MAP_MAX_W-1:0] MAP_EXT = MAP_MAX_W'(ROUTE_MAP);

    logic [MAX_OUT_NUM-1:0] mask;
    logic [MAX_OUT_NUM-1:0] sel_oh;
    logic [MAX_OUT_NUM-1:0] ch_rdy_ext;
    logic [OUT_NUM-1:0]     ch_rdy;
    logic [OUT_NUM-1:0]     push;
    logic [PAY_W-1:0]       in_pay;
    logic                   unmapped;
    logic                   drop;

    if (OUT_NUM < 1 || OUT_NUM > MAX_OUT_NUM) begin : g_bad_out_num
        $error("OUT_NUM must be in 1..%0d", MAX_OUT_NUM);
    end
    if (ID_W > MAX_ID_W) begin : g_bad_id_w
        $error("ID_W must not exceed %0d", MAX_ID_W);
    end
    for (genvar t = 0; t < 2 ** ID_W; t++) begin : g_map_chk
        if (count_ones(get_route_mask(MAP_EXT, t, OUT_NUM)) > 1) begin : g_multi
            $error("ROUTE_MAP entry %0d selects more than one channel", t);
        end
    end

    // A multi-bit mask is misconfigured; isolating the lowest set bit keeps routing deterministic.
    always_comb begin
        mask       = get_route_mask(MAP_EXT, 32'(in0_tgt_id), OUT_NUM);
        sel_oh     = mask & (~mask + 1'b1);
        ch_rdy_ext = MAX_OUT_NUM'(ch_rdy);
    end

    assign unmapped = (sel_oh == '0);
    assign in0_rdy  = unmapped | (|(sel_oh & ch_rdy_ext));
    assign drop     = in0_vld & unmapped;
    assign push     = OUT_NUM'(sel_oh) & {OUT_NUM{in0_vld}};
    assign in_pay   = {in0_opcode, in0_data, in0_src_id, in0_tgt_id};

    for (genvar i = 0; i < OUT_NUM; i++) begin : g_ch
        logic [PAY_W-1:0] pay;

        toy_bus_skid_buf #(
            .W(PAY_W)
        ) u_buf (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_vld   (push[i]),
            .in_rdy   (ch_rdy[i]),
            .in_data  (in_pay),
            .out_vld  (out_vld[i]),
            .out_rdy  (out_rdy[i]),
            .out_data (pay)
        );

        assign {out_opcode[i], out_data[i*DATA_W +: DATA_W],
                out_src_id[i*ID_W +: ID_W], out_tgt_id[i*ID_W +: ID_W]} = pay;
    end

    // Drop reporting: a one-cycle pulse, the last dropped tgt_id, and a saturating count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_vld    <= 1'b0;
            err_tgt_id <= '0;
            err_cnt    <= '0;
        end else begin
            err_vld <= drop;
            if (drop) begin
                err_tgt_id <= in0_tgt_id;
                if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_toy_bus_ddec_node_reg.sv
// Scoreboard bench for toy_bus_ddec_node_reg: directed scenarios plus random ACK traffic,
// with expected beats derived from the route map and checked by an independent monitor.
module tb_toy_bus_ddec_node_reg;

    localparam int OUT_NUM   = 2;
    localparam int DATA_W    = 32;
    localparam int ID_W      = 4;
    localparam int ERR_CNT_W = 16;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic                      in0_vld;
    logic                      in0_rdy;
    logic                      in0_opcode;
    logic [DATA_W-1:0]         in0_data;
    logic [ID_W-1:0]           in0_src_id;
    logic [ID_W-1:0]           in0_tgt_id;
    logic [OUT_NUM-1:0]        out_vld;
    logic [OUT_NUM-1:0]        out_rdy;
    logic [OUT_NUM-1:0]        out_opcode;
    logic [OUT_NUM*DATA_W-1:0] out_data;
    logic [OUT_NUM*ID_W-1:0]   out_src_id;
    logic [OUT_NUM*ID_W-1:0]   out_tgt_id;
    logic                      err_vld;
    logic [ID_W-1:0]           err_tgt_id;
    logic [ERR_CNT_W-1:0]      err_cnt;

    int          tests = 0;
    int          failed = 0;
    logic [31:0] route_map = 32'h0000_2009;
    logic [63:0] exp_q[OUT_NUM][$];
    logic [3:0]  err_q[$];
    int          model_cnt = 0;
    int          err_pulses = 0;
    int          pop_cnt[OUT_NUM];
    bit          held_vld[OUT_NUM];
    logic [63:0] held[OUT_NUM];
    int          rdy_mode[OUT_NUM];

    toy_bus_ddec_node_reg dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in0_vld    (in0_vld),
        .in0_rdy    (in0_rdy),
        .in0_opcode (in0_opcode),
        .in0_data   (in0_data),
        .in0_src_id (in0_src_id),
        .in0_tgt_id (in0_tgt_id),
        .out_vld    (out_vld),
        .out_rdy    (out_rdy),
        .out_opcode (out_opcode),
        .out_data   (out_data),
        .out_src_id (out_src_id),
        .out_tgt_id (out_tgt_id),
        .err_vld    (err_vld),
        .err_tgt_id (err_tgt_id),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests++;
        if (actual !== expected) begin
            failed++;
            $display("[TB] FAIL %s: actual %0h required %0h", name, actual, expected);
        end
    endtask

    // Lowest channel whose bit is set for this target, or -1 when the target is unmapped.
    function automatic int refRoute(input logic [3:0] tgt);
        for (int i = 0; i < OUT_NUM; i++) begin
            if (route_map[int'(tgt) * OUT_NUM + i]) return i;
        end
        return -1;
    endfunction

    task automatic applyStimulus(input logic [3:0] tgt, input logic [31:0] data, input logic op,
                                 input logic [3:0] src, input int max_wait, output bit accepted);
        int ch;
        accepted   = 1'b0;
        in0_vld    = 1'b1;
        in0_tgt_id = tgt;
        in0_data   = data;
        in0_opcode = op;
        in0_src_id = src;
        for (int w = 0; w < max_wait && !accepted; w++) begin
            #1;
            if (in0_rdy === 1'b1) begin
                accepted = 1'b1;
                ch = refRoute(tgt);
                if (ch < 0) err_q.push_back(tgt);
                else        exp_q[ch].push_back(64'({op, data, src, tgt}));
            end
            @(negedge clk);
        end
        in0_vld = 1'b0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        out_rdy = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < OUT_NUM; i++) begin
                case (rdy_mode[i])
                    0:       out_rdy[i] = 1'b0;
                    1:       out_rdy[i] = 1'b1;
                    default: out_rdy[i] = 1'($urandom_range(0, 1));
                endcase
            end
        end
    end

    // Monitor: pops expected beats on each handshake and checks stalled outputs hold still.
    always @(negedge clk) begin
        logic [63:0] cur;
        logic [63:0] exp_beat;
        logic [3:0]  exp_tgt;
        if (rst_n === 1'b1) begin
            for (int i = 0; i < OUT_NUM; i++) begin
                cur = 64'({out_opcode[i], out_data[i*DATA_W +: DATA_W],
                           out_src_id[i*ID_W +: ID_W], out_tgt_id[i*ID_W +: ID_W]});
                if (out_vld[i] === 1'b1) begin
                    if (held_vld[i]) checkOutput("stall_hold", cur, held[i]);
                    if (out_rdy[i]) begin
                        held_vld[i] = 1'b0;
                        if (exp_q[i].size() == 0) begin
                            checkOutput("unexpected_out", 64'(out_vld[i]), 64'd0);
                        end else begin
                            exp_beat = exp_q[i].pop_front();
                            checkOutput($sformatf("ch%0d_beat", i), cur, exp_beat);
                            pop_cnt[i]++;
                        end
                    end else begin
                        held_vld[i] = 1'b1;
                        held[i]     = cur;
                    end
                end else begin
                    if (held_vld[i]) checkOutput("stall_vld_drop", 64'(out_vld[i]), 64'd1);
                    held_vld[i] = 1'b0;
                end
            end
            if (err_vld === 1'b1) begin
                err_pulses++;
                if (err_q.size() == 0) begin
                    checkOutput("spurious_err", 64'(err_vld), 64'd0);
                end else begin
                    exp_tgt = err_q.pop_front();
                    if (model_cnt < 65535) model_cnt++;
                    checkOutput("err_tgt_id", 64'(err_tgt_id), 64'(exp_tgt));
                    checkOutput("err_cnt", 64'(err_cnt), 64'(model_cnt));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: actual timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit acc;
        int base;
        logic [3:0] t;
        int r;

        rst_n      = 1'b0;
        in0_vld    = 1'b0;
        in0_opcode = 1'b0;
        in0_data   = '0;
        in0_src_id = '0;
        in0_tgt_id = '0;
        for (int i = 0; i < OUT_NUM; i++) begin
            rdy_mode[i] = 1;
            pop_cnt[i]  = 0;
            held_vld[i] = 1'b0;
        end
        waitCycles(3);
        checkOutput("reset_out_vld", 64'(out_vld), 64'd0);
        checkOutput("reset_err_vld", 64'(err_vld), 64'd0);
        checkOutput("reset_err_tgt", 64'(err_tgt_id), 64'd0);
        checkOutput("reset_err_cnt", 64'(err_cnt), 64'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("rdy_after_reset", 64'(in0_rdy), 64'd1);
        @(negedge clk);

        // Single beat to ch0 appears one cycle after acceptance.
        applyStimulus(4'h0, 32'hA5A5_0001, 1'b0, 4'h3, 1, acc);
        checkOutput("t1_accept", 64'(acc), 64'd1);
        checkOutput("t1_vld0", 64'(out_vld[0]), 64'd1);
        checkOutput("t1_vld1", 64'(out_vld[1]), 64'd0);
        checkOutput("t1_data", 64'(out_data[31:0]), 64'hA5A5_0001);

        // Back-to-back burst to ch1 at full rate.
        base = pop_cnt[1];
        for (int k = 0; k < 8; k++) begin
            applyStimulus(4'h6, 32'h6000_0000 + 32'(k), k[0], 4'(k), 1, acc);
            checkOutput("t2_accept", 64'(acc), 64'd1);
        end
        @(negedge clk);
        checkOutput("t2_pops", 64'(pop_cnt[1] - base), 64'd8);

        // Stalled ch1 fills after two beats, then drains in order.
        rdy_mode[1] = 0;
        waitCycles(2);
        applyStimulus(4'h1, 32'h3000_0001, 1'b1, 4'h5, 1, acc);
        checkOutput("t3_accept_a", 64'(acc), 64'd1);
        applyStimulus(4'h1, 32'h3000_0002, 1'b0, 4'h5, 1, acc);
        checkOutput("t3_accept_b", 64'(acc), 64'd1);
        in0_vld    = 1'b1;
        in0_tgt_id = 4'h1;
        in0_data   = 32'h3000_0003;
        #1;
        checkOutput("t3_full_rdy", 64'(in0_rdy), 64'd0);
        rdy_mode[1] = 1;
        applyStimulus(4'h1, 32'h3000_0003, 1'b1, 4'h5, 10, acc);
        checkOutput("t3_accept_c", 64'(acc), 64'd1);
        waitCycles(5);
        checkOutput("t3_drained", 64'(exp_q[1].size()), 64'd0);

        // Full ch1 does not block traffic for ch0.
        rdy_mode[1] = 0;
        waitCycles(2);
        applyStimulus(4'h1, 32'h4100_0001, 1'b0, 4'h2, 1, acc);
        applyStimulus(4'h1, 32'h4100_0002, 1'b0, 4'h2, 1, acc);
        applyStimulus(4'h0, 32'h4000_0000, 1'b1, 4'h1, 1, acc);
        checkOutput("t4_hol_accept", 64'(acc), 64'd1);
        waitCycles(3);
        checkOutput("t4_ch0_drained", 64'(exp_q[0].size()), 64'd0);
        checkOutput("t4_ch1_held", 64'(out_vld[1]), 64'd1);

        // Unmapped target is consumed and reported.
        base = err_pulses;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(4'hF, 32'hDEAD_0000 + 32'(k), 1'b0, 4'h7, 1, acc);
            checkOutput("t5_accept", 64'(acc), 64'd1);
        end
        waitCycles(3);
        checkOutput("t5_pulses", 64'(err_pulses - base), 64'd3);
        checkOutput("t5_err_tgt", 64'(err_tgt_id), 64'hF);
        checkOutput("t5_err_cnt", 64'(err_cnt), 64'd3);
        checkOutput("t5_err_vld_low", 64'(err_vld), 64'd0);
        checkOutput("t5_ch0_idle", 64'(out_vld[0]), 64'd0);

        // Asynchronous reset with both buffers full.
        rdy_mode[0] = 0;
        waitCycles(2);
        applyStimulus(4'h0, 32'h5000_0001, 1'b0, 4'h1, 1, acc);
        applyStimulus(4'h0, 32'h5000_0002, 1'b0, 4'h1, 1, acc);
        checkOutput("t6_both_vld", 64'(out_vld), 64'd3);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_vld", 64'(out_vld), 64'd0);
        checkOutput("t6_rst_err_cnt", 64'(err_cnt), 64'd0);
        checkOutput("t6_rst_err_vld", 64'(err_vld), 64'd0);
        for (int i = 0; i < OUT_NUM; i++) begin
            exp_q[i].delete();
            held_vld[i] = 1'b0;
        end
        err_q.delete();
        model_cnt = 0;
        waitCycles(2);
        rst_n = 1'b1;
        for (int i = 0; i < OUT_NUM; i++) rdy_mode[i] = 1;
        applyStimulus(4'h0, 32'hA5A5_0002, 1'b1, 4'h9, 1, acc);
        checkOutput("t6_accept", 64'(acc), 64'd1);
        checkOutput("t6_vld0", 64'(out_vld[0]), 64'd1);
        checkOutput("t6_data", 64'(out_data[31:0]), 64'hA5A5_0002);

        // Random traffic with random back-pressure.
        for (int i = 0; i < OUT_NUM; i++) rdy_mode[i] = 2;
        for (int n = 0; n < 300; n++) begin
            r = int'($urandom_range(0, 9));
            if (r < 3)      t = 4'h0;
            else if (r < 6) t = 4'h1;
            else if (r < 7) t = 4'h6;
            else            t = 4'($urandom_range(0, 15));
            applyStimulus(t, $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 64, acc);
            checkOutput("rand_accept", 64'(acc), 64'd1);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        for (int i = 0; i < OUT_NUM; i++) rdy_mode[i] = 1;
        waitCycles(8);
        for (int i = 0; i < OUT_NUM; i++) begin
            checkOutput($sformatf("final_drain_ch%0d", i), 64'(exp_q[i].size()), 64'd0);
        end
        checkOutput("final_err_q", 64'(err_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/toy_bus_ddec_node_reg.md
Name: toy_bus_ddec_node_reg

Overview:
Parametrised, registered successor to the combinational ACK decode node. It accepts one ToyBusAck stream and steers each beat to one of OUT_NUM output channels using a parameter route map indexed by tgt_id. Each output channel has a 2-entry skid buffer, so every output is registered and a stalled channel does not block traffic bound for other channels once that beat has been accepted. Beats addressed to an unmapped tgt_id are consumed, dropped and reported. The block sits between the bus arbiter node and the downstream target ports (dtcm, itcm, periph).

Parameters:
OUT_NUM, 2, number of output channels (1..8)
DATA_W, 32, payload data width
ID_W, 4, src_id/tgt_id width; the route map has 2**ID_W entries
ROUTE_MAP, 32'h0000_2009, flat vector of (2**ID_W)*OUT_NUM bits; bits [t*OUT_NUM +: OUT_NUM] are the one-hot channel mask for tgt_id t, and all-zero means unmapped. The default maps tgt 0->ch0 and tgt 1,6->ch1.
ERR_CNT_W, 16, width of the drop counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in0_vld  in  1  input beat valid
in0_rdy  out  1  input ready
in0_opcode  in  1  ack opcode
in0_data  in  DATA_W  ack data
in0_src_id  in  ID_W  source id
in0_tgt_id  in  ID_W  target id, used for routing
out_vld  out  OUT_NUM  per-channel valid
out_rdy  in  OUT_NUM  per-channel ready
out_opcode  out  OUT_NUM  per-channel opcode
out_data  out  OUT_NUM*DATA_W  channel i at [i*DATA_W +: DATA_W]
out_src_id  out  OUT_NUM*ID_W  per-channel src_id
out_tgt_id  out  OUT_NUM*ID_W  per-channel tgt_id
err_vld  out  1  one-cycle pulse when an unmapped beat is dropped
err_tgt_id  out  ID_W  tgt_id of the last dropped beat (held until the next drop)
err_cnt  out  ERR_CNT_W  saturating count of dropped beats

Behaviour:
- Clock and reset: single clock clk. Reset rst_n is asynchronous, active-low.
- Reset values: all out_vld=0, err_vld=0, err_tgt_id=0, err_cnt=0, all buffer counts=0. in0_rdy becomes combinationally valid after reset is released.
- Decode: sel = ROUTE_MAP[in0_tgt_id*OUT_NUM +: OUT_NUM]. If sel has more than one bit set, the lowest set bit wins. A multi-bit sel is a configuration error and is flagged by an elaboration-time assertion.
- Ready: in0_rdy = (sel==0) | (count[ch] < 2), where ch is the selected channel. in0_rdy is combinational from in0_tgt_id and registered counts; there is no path from out_rdy to in0_rdy.
- Accept: a beat is accepted when in0_vld & in0_rdy.
  - Mapped beat: written to the selected channel's skid buffer.
  - Unmapped beat: dropped. Next cycle err_vld=1, err_tgt_id is loaded, and err_cnt increments. err_cnt saturates at all-ones.
- Skid buffer, per channel: 2 entries, FIFO order. out_vld = (count != 0), head entry driven onto the out_* fields. Pop on out_vld & out_rdy.
  - Push and pop in the same cycle: count is unchanged.
  - Push into an empty buffer: visible on out_vld the next cycle (latency 1).
  - Full throughput of one beat per cycle per channel is sustained while out_rdy=1.
- Ordering: preserved within a channel. No ordering is guaranteed across channels.
- Output stability: while out_vld=1 and out_rdy=0, all out_* fields of that channel hold stable.
- Full channel: a beat for a full channel stalls the input (head-of-line). Beats already buffered for other channels continue to drain.
- Reset mid-operation: asserting rst_n=0 flushes all buffered beats with no output. err_cnt clears.

Decomposition:
- Shared package toy_bus_pkg: ToyBusAck payload struct (opcode, data, src_id, tgt_id), default DATA_W and ID_W, and a route-map helper function get_route_mask(map, tgt, n).
- One sub-module, toy_bus_skid_buf: a 2-entry valid/ready buffer parametrised on payload width, instantiated OUT_NUM times.

Test Plan:
- Defaults; tgt=0, data=32'hA5A5_0001, out_rdy=2'b11 -> out_vld[0]=1 one cycle later with the same data; out_vld[1] stays 0.
- tgt=6 beats back-to-back x8, out_rdy[1]=1 -> 8 beats on ch1 in order, one per cycle; in0_rdy never drops.
- out_rdy[1]=0; 3 beats to tgt=1 -> first two accepted, in0_rdy=0 on the third. Raise out_rdy[1] -> all 3 delivered in order with no loss or duplication.
- ch1 full and stalled; beat to tgt=0 sent -> stall is head-of-line only. A beat to tgt=0 presented while ch1 is full is accepted and ch0 drains normally.
- tgt=4'hF (unmapped) x3 -> in0_rdy=1, no out_vld on any channel, err_vld pulses 3 times, err_tgt_id=4'hF, err_cnt=3.
- Assert rst_n low mid-stream with both buffers holding 2 beats -> out_vld=0 immediately (asynchronously), err_cnt=0. After release, a new beat to tgt=0 is delivered with latency 1.
